// File: rtl/pkt_commit_fifo.sv
// Packet buffer that stores words speculatively and releases them downstream only after a keep verdict.
// Optional statistics counters are built only when PKT_COMMIT_FIFO_STATS_EN is defined.
module pkt_commit_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic                  verdict_valid,
    input  logic                  verdict_drop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkts_kept,
    output logic [31:0]           pkts_dropped
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, HDR, BODY, WAIT_VERDICT} state_e;

    state_e                         state_q, state_d;
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                  commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic                           ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]          out_ctrl_q, out_ctrl_d;
    logic                           out_wr_q, out_wr_d;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] used;
    logic          full;
    logic          wr_accept;
    logic          last_word;
    logic          store;
    logic          overflow_now;
    logic          verdict_take;
    logic          verdict_discard;
    logic          rd_en;

    assign used = wr_ptr_q - rd_ptr_q;
    assign full = used[ADDR_WIDTH];
    assign in_rdy = reset && (state_q != WAIT_VERDICT) && (used <= PW'(DEPTH - 2));

    always_comb begin
        wr_accept = 1'b0;
        last_word = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (in_wr && (in_ctrl != '0)) begin
                    wr_accept = 1'b1;
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (in_wr) begin
                    wr_accept = 1'b1;
                    if (in_ctrl == '0) state_d = BODY;
                end
            end
            BODY: begin
                if (in_wr) begin
                    wr_accept = 1'b1;
                    if (in_ctrl != '0) begin
                        last_word = 1'b1;
                        state_d   = WAIT_VERDICT;
                    end
                end
            end
            default: ;
        endcase
        if (verdict_take) state_d = IDLE;
    end

    assign store           = wr_accept && !full;
    assign overflow_now    = ovf_q || (wr_accept && full);
    assign verdict_take    = verdict_valid && (last_word || (state_q == WAIT_VERDICT));
    assign verdict_discard = verdict_take && (verdict_drop || overflow_now);
    assign rd_en           = (rd_ptr_q != commit_ptr_q) && out_rdy;

    always_comb begin
        wr_ptr_d     = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ovf_d        = overflow_now;
        // A kept packet commits up to the pointer that includes a same-cycle last word.
        if (verdict_take) begin
            ovf_d = 1'b0;
            if (verdict_discard) wr_ptr_d = commit_ptr_q;
            else                 commit_ptr_d = wr_ptr_d;
        end
        rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_wr_d   = rd_en;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        if (rd_en) {out_ctrl_d, out_data_d} = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            out_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            out_data_q   <= out_data_d;
            out_ctrl_q   <= out_ctrl_d;
            out_wr_q     <= out_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && store) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {in_ctrl, in_data};
    end

    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;
    assign out_wr   = out_wr_q;

`ifdef PKT_COMMIT_FIFO_STATS_EN
    logic [31:0] pkts_kept_q, pkts_kept_d;
    logic [31:0] pkts_dropped_q, pkts_dropped_d;

    always_comb begin
        pkts_kept_d    = pkts_kept_q;
        pkts_dropped_d = pkts_dropped_q;
        if (verdict_take) begin
            if (verdict_discard) pkts_dropped_d = pkts_dropped_q + 32'd1;
            else                 pkts_kept_d    = pkts_kept_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pkts_kept_q    <= '0;
            pkts_dropped_q <= '0;
        end else begin
            pkts_kept_q    <= pkts_kept_d;
            pkts_dropped_q <= pkts_dropped_d;
        end
    end

    assign pkts_kept    = pkts_kept_q;
    assign pkts_dropped = pkts_dropped_q;
`else
    assign pkts_kept    = '0;
    assign pkts_dropped = '0;
`endif
endmodule

// File: tb/tb_pkt_commit_fifo.sv
// Directed bench for pkt_commit_fifo: keep, late drop, overflow, pointer wrap and mid-packet reset.
module tb_pkt_commit_fifo;
`ifdef PKT_COMMIT_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic        verdict_valid = 1'b0;
    logic        verdict_drop = 1'b0;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [31:0] pkts_kept;
    logic [31:0] pkts_dropped;

    logic rdy_static = 1'b0;
    logic tog_en = 1'b0;
    logic tog = 1'b0;

    int total = 0;
    int bad = 0;

    logic [71:0] got_q[$];
    logic [71:0] exp_q[$];

    pkt_commit_fifo #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(9)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .verdict_valid(verdict_valid), .verdict_drop(verdict_drop),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .pkts_kept(pkts_kept), .pkts_dropped(pkts_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tog_en) tog <= ~tog;
    assign out_rdy = tog_en ? tog : rdy_static;

    always @(negedge clk) if (out_wr) got_q.push_back({out_ctrl, out_data});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_word(input int id, input int idx);
        return {32'(id), 32'(idx)};
    endfunction

    task automatic wait_rdy();
        int n = 0;
        while (!in_rdy && n < 2000) begin
            tick();
            n++;
        end
        if (n == 2000) check("in_rdy_wait", 64'(in_rdy), 64'd1);
    endtask

    task automatic send_pkt(input int id, input int n, input bit vv, input bit vd,
                            input bit honor, input bit expect_out);
        logic [7:0] c;
        for (int i = 0; i < n; i++) begin
            if (honor) wait_rdy();
            c = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h01 : 8'h00);
            in_ctrl = c;
            in_data = mk_word(id, i);
            in_wr   = 1'b1;
            if (i == n - 1) begin
                verdict_valid = vv;
                verdict_drop  = vd;
            end
            if (expect_out) exp_q.push_back({c, mk_word(id, i)});
            tick();
            in_wr = 1'b0;
            verdict_valid = 1'b0;
            verdict_drop = 1'b0;
        end
    endtask

    task automatic give_verdict(input bit vd);
        verdict_valid = 1'b1;
        verdict_drop  = vd;
        tick();
        verdict_valid = 1'b0;
        verdict_drop  = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_data"}, got_q[i][63:0], exp_q[i][63:0]);
            check({tag, "_ctrl"}, 64'(got_q[i][71:64]), 64'(exp_q[i][71:64]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_kept", 64'(pkts_kept), 64'd0);
        check("rst_dropped", 64'(pkts_dropped), 64'd0);
        reset = 1'b1;
        tick();
        check("post_rst_in_rdy", 64'(in_rdy), 64'd1);

        // Keep verdict with the last word
        rdy_static = 1'b1;
        send_pkt(1, 5, 1'b1, 1'b0, 1'b1, 1'b1);
        check("keep_out_wr_verdict_edge", 64'(out_wr), 64'd0);
        check("keep_commit_ptr", 64'(dut.commit_ptr_q), 64'd5);
        tick();
        check("keep_out_wr_next", 64'(out_wr), 64'd1);
        check("keep_first_data", out_data, mk_word(1, 0));
        drain(5, 20);
        compare_stream("keep");
        check("keep_kept", 64'(pkts_kept), STATS ? 64'd1 : 64'd0);

        // Drop verdict four cycles after the last word
        send_pkt(2, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            check("late_in_rdy", 64'(in_rdy), 64'd0);
            check("late_out_wr", 64'(out_wr), 64'd0);
            if (c < 4) tick();
            else       give_verdict(1'b1);
        end
        check("late_no_out", 64'(got_q.size()), 64'd0);
        check("late_wr_ptr", 64'(dut.wr_ptr_q), 64'd5);
        check("late_commit_ptr", 64'(dut.commit_ptr_q), 64'd5);
        check("late_dropped", 64'(pkts_dropped), STATS ? 64'd1 : 64'd0);
        check("late_in_rdy_after", 64'(in_rdy), 64'd1);

        // 600-word packet into a stalled output: overflow forces a drop
        rdy_static = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            in_ctrl = (k == 1) ? 8'hFF : ((k == 600) ? 8'h01 : 8'h00);
            in_data = mk_word(9, k);
            in_wr   = 1'b1;
            if (k == 600) verdict_valid = 1'b1;
            tick();
            in_wr = 1'b0;
            verdict_valid = 1'b0;
            if (k == 510) check("ovf_in_rdy_510", 64'(in_rdy), 64'd1);
            if (k == 511) check("ovf_in_rdy_511", 64'(in_rdy), 64'd0);
            if (k == 512) check("ovf_wr_ptr_full", 64'(dut.wr_ptr_q), 64'd517);
        end
        check("ovf_wr_ptr", 64'(dut.wr_ptr_q), 64'd5);
        check("ovf_commit_ptr", 64'(dut.commit_ptr_q), 64'd5);
        check("ovf_rd_ptr", 64'(dut.rd_ptr_q), 64'd5);
        check("ovf_dropped", 64'(pkts_dropped), STATS ? 64'd2 : 64'd0);
        check("ovf_kept", 64'(pkts_kept), STATS ? 64'd1 : 64'd0);
        rdy_static = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("ovf_no_out", 64'(got_q.size()), 64'd0);

        // Large kept packet moves the pointers close to the wrap point
        send_pkt(3, 400, 1'b1, 1'b0, 1'b1, 1'b1);
        drain(400, 1000);
        compare_stream("filler");

        // A kept, B dropped, C kept late, with out_rdy toggling; C crosses the wrap
        tog_en = 1'b1;
        send_pkt(4, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        send_pkt(5, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        send_pkt(6, 150, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        give_verdict(1'b0);
        drain(158, 2000);
        compare_stream("abc");
        check("abc_rd_ptr", 64'(dut.rd_ptr_q), 64'd563);
        check("abc_commit_ptr", 64'(dut.commit_ptr_q), 64'd563);
        check("abc_kept", 64'(pkts_kept), STATS ? 64'd4 : 64'd0);
        check("abc_dropped", 64'(pkts_dropped), STATS ? 64'd3 : 64'd0);

        // Reset in the body of a packet while a kept packet is still buffered
        tog_en = 1'b0;
        rdy_static = 1'b0;
        send_pkt(7, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_ctrl = (i == 0) ? 8'hFF : 8'h00;
            in_data = mk_word(10, i);
            in_wr   = 1'b1;
            tick();
            in_wr = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
        tick();
        check("mid_rst_out_wr", 64'(out_wr), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_kept", 64'(pkts_kept), 64'd0);
        check("mid_rst_dropped", 64'(pkts_dropped), 64'd0);
        check("mid_rst_wr_ptr", 64'(dut.wr_ptr_q), 64'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_in_rdy_after", 64'(in_rdy), 64'd1);
        rdy_static = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_no_out", 64'(got_q.size()), 64'd0);
        send_pkt(8, 4, 1'b1, 1'b0, 1'b1, 1'b1);
        drain(4, 20);
        compare_stream("fresh");
        check("fresh_kept", 64'(pkts_kept), STATS ? 64'd1 : 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
